bubble_out_buffer: RTL and testbench

BUBBLE_OUT_BUFFER -- requirements
Module: bubble_out_buffer

---
 rtl/bubble_pkg.sv | 29 ++
 rtl/bubble_bit_ram.sv | 34 +++
 rtl/bubble_out_buffer.sv | 130 +++++++++++++
 tb/tb_bubble_out_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bubble_pkg
// Purpose  : Shared constants, types and parameter checks for the bubble
//            output buffer.
// Revision : 1.0
// ============================================================================
package bubble_pkg;

    localparam logic [2:0] ACCTYPE_IDLE = 3'b000;

    // Sub-cycle phases within one bubble bit cycle
    localparam logic [1:0] TICK_LATCH = 2'd0;
    localparam logic [1:0] TICK_OUT1  = 2'd1;
    localparam logic [1:0] TICK_OUT2  = 2'd2;
    localparam logic [1:0] TICK_GAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ACTIVE      = 2'd1,
        ST_ACTIVE_PEND = 2'd2
    } swap_state_t;

    function automatic bit chans_legal(input int channels);
        return (channels == 2) || (channels == 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_bit_ram.sv
`default_nettype none
// ============================================================================
// Module   : bubble_bit_ram
// Purpose  : 1-bit wide simple dual-port RAM with a registered read port.
// Revision : 1.0
// ============================================================================
module bubble_bit_ram #(
    parameter int ADDRW = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic             wdata,
    input  logic             re,
    input  logic [ADDRW-1:0] raddr,
    output logic             rdata
);

    logic r_mem [2**ADDRW];
    logic r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bubble_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bubble_out_buffer
// Purpose  : Double-banked bubble data output buffer; one bank is loaded while
//            the other is streamed out, with a deferred bank swap.
// Revision : 1.0
// ============================================================================
module bubble_out_buffer
    import bubble_pkg::*;
#(
    parameter  int CHANNELS = 2,
    parameter  int CYCLEW   = 12,
    localparam int CHW      = $clog2(CHANNELS)
) (
    input  logic                  MCLK,
    input  logic                  RST,
    input  logic [2:0]            ACCTYPE,
    input  logic [CYCLEW-1:0]     BOUTCYCLENUM,
    input  logic [1:0]            BOUTTICKS,
    input  logic [CHW+CYCLEW-1:0] OUTBUFWADDR,
    input  logic                  nOUTBUFWCLKEN,
    input  logic                  OUTBUFWDATA,
    input  logic                  SWAP,
    output logic                  BANKRDY,
    output logic [CHANNELS-1:0]   DOUT,
    output logic                  OVERRUN
);

    if (!chans_legal(CHANNELS)) begin : g_bad_channels
        $error("bubble_out_buffer: CHANNELS must be 2 or 4");
    end

    swap_state_t r_state;
    logic        r_rd_bank;     // 0: read A / write B, 1: read B / write A
    logic        r_bankrdy;
    logic        r_overrun;
    logic        r_rd_valid;

    logic                      w_active;
    logic                      w_wr_en;
    logic                      w_wr_bank;
    logic [CHW-1:0]            w_wr_ch;
    logic [CYCLEW-1:0]         w_wr_cyc;
    logic                      w_rd_en;
    logic                      w_out_phase;
    logic [1:0][CHANNELS-1:0]  w_bank_q;

    assign w_active    = (ACCTYPE != ACCTYPE_IDLE);
    assign w_wr_en     = ~nOUTBUFWCLKEN;
    assign w_wr_bank   = ~r_rd_bank;
    assign w_wr_ch     = OUTBUFWADDR[CHW+CYCLEW-1:CYCLEW];
    assign w_wr_cyc    = OUTBUFWADDR[CYCLEW-1:0];
    assign w_rd_en     = w_active && (BOUTTICKS == TICK_LATCH);
    assign w_out_phase = (BOUTTICKS == TICK_OUT1) || (BOUTTICKS == TICK_OUT2);

    // Both banks are read every latch tick; the output mux picks the read bank,
    // so the write bank is only ever written and never observed.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            bubble_bit_ram #(
                .ADDRW (CYCLEW)
            ) u_ram (
                .clk   (MCLK),
                .we    (w_wr_en && (w_wr_bank == 1'(b)) && (w_wr_ch == CHW'(c))),
                .waddr (w_wr_cyc),
                .wdata (OUTBUFWDATA),
                .re    (w_rd_en),
                .raddr (BOUTCYCLENUM),
                .rdata (w_bank_q[b][c])
            );
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_rd_bank <= 1'b0;
            r_bankrdy <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (SWAP && (r_state == ST_ACTIVE_PEND)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_ACTIVE: begin
                    if (!w_active) begin
                        r_state   <= ST_IDLE;
                        r_bankrdy <= 1'b1;
                        if (SWAP) begin
                            r_rd_bank <= ~r_rd_bank;
                        end
                    end else if (SWAP) begin
                        r_state   <= ST_ACTIVE_PEND;
                        r_bankrdy <= 1'b0;
                    end else begin
                        r_state   <= ST_ACTIVE;
                        r_bankrdy <= 1'b1;
                    end
                end
                ST_ACTIVE_PEND: begin
                    if (!w_active) begin
                        r_state   <= ST_IDLE;
                        r_bankrdy <= 1'b1;
                        r_rd_bank <= ~r_rd_bank;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bankrdy <= 1'b1;
                end
            endcase
        end
    end

    // Marks that the RAM output registers hold data for the current bit cycle
    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_rd_valid <= 1'b0;
        end else if (BOUTTICKS == TICK_LATCH) begin
            r_rd_valid <= w_active;
        end
    end

    assign BANKRDY = r_bankrdy | RST;
    assign OVERRUN = r_overrun & ~RST;
    assign DOUT    = (w_active && w_out_phase && r_rd_valid && !RST)
                     ? w_bank_q[r_rd_bank] : '0;

endmodule
`default_nettype wire

// File: tb/tb_bubble_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bubble_out_buffer
// Purpose  : Scoreboard bench for bubble_out_buffer (CHANNELS=4, CYCLEW=12).
// Revision : 1.0
// ============================================================================
module tb_bubble_out_buffer;

    localparam int CH    = 4;
    localparam int CW    = 12;
    localparam int DEPTH = 4096;
    localparam int NADDR = 24;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic [2:0]    ACCTYPE = 3'd0;
    logic [CW-1:0] BOUTCYCLENUM = '0;
    logic [1:0]    BOUTTICKS = 2'd0;
    logic [13:0]   OUTBUFWADDR = '0;
    logic          nOUTBUFWCLKEN = 1'b1;
    logic          OUTBUFWDATA = 1'b0;
    logic          SWAP = 1'b0;
    logic          BANKRDY;
    logic [CH-1:0] DOUT;
    logic          OVERRUN;

    always #5 clk = ~clk;

    bubble_out_buffer #(.CHANNELS(CH), .CYCLEW(CW)) dut (
        .MCLK          (clk),
        .RST           (RST),
        .ACCTYPE       (ACCTYPE),
        .BOUTCYCLENUM  (BOUTCYCLENUM),
        .BOUTTICKS     (BOUTTICKS),
        .OUTBUFWADDR   (OUTBUFWADDR),
        .nOUTBUFWCLKEN (nOUTBUFWCLKEN),
        .OUTBUFWDATA   (OUTBUFWDATA),
        .SWAP          (SWAP),
        .BANKRDY       (BANKRDY),
        .DOUT          (DOUT),
        .OVERRUN       (OVERRUN)
    );

    typedef struct {
        int            id;
        logic [CH-1:0] dout;
        logic          bankrdy;
        logic          overrun;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   nstep  = 0;

    // Reference model: bank contents and the observable buffer state
    bit          mdl [2][CH][DEPTH];
    bit          m_rdbank = 1'b0;
    bit          m_pend   = 1'b0;
    bit          m_ovr    = 1'b0;
    bit          m_valid  = 1'b0;
    bit [CH-1:0] m_latch  = '0;

    function automatic int addr_of(input int i);
        return (i < 16) ? i : (DEPTH - NADDR) + i;
    endfunction

    task automatic step(input bit r, input bit [2:0] acc, input int cyc, input int tk,
                        input bit we, input int wch, input int wcyc, input bit wd,
                        input bit sw);
        exp_t e;
        bit   do_swap;
        @(posedge clk);
        #1;
        RST           = r;
        ACCTYPE       = acc;
        BOUTCYCLENUM  = CW'(cyc);
        BOUTTICKS     = 2'(tk);
        OUTBUFWADDR   = {2'(wch), CW'(wcyc)};
        nOUTBUFWCLKEN = ~we;
        OUTBUFWDATA   = wd;
        SWAP          = sw;

        e.id      = nstep;
        e.dout    = (!r && acc != 3'd0 && (tk == 1 || tk == 2) && m_valid) ? m_latch : '0;
        e.bankrdy = r ? 1'b1 : !m_pend;
        e.overrun = r ? 1'b0 : m_ovr;
        sb.push_back(e);
        nstep++;

        if (r) begin
            m_rdbank = 1'b0;
            m_pend   = 1'b0;
            m_ovr    = 1'b0;
            m_valid  = 1'b0;
        end else begin
            if (we) mdl[m_rdbank ^ 1'b1][wch][wcyc] = wd;
            if (tk == 0) begin
                m_valid = (acc != 3'd0);
                if (acc != 3'd0)
                    for (int c = 0; c < CH; c++) m_latch[c] = mdl[m_rdbank][c][cyc % DEPTH];
            end
            do_swap = (acc == 3'd0) && (m_pend || sw);
            if (sw && m_pend) m_ovr = 1'b1;
            m_pend = (acc != 3'd0) && (m_pend || sw);
            if (do_swap) m_rdbank = m_rdbank ^ 1'b1;
        end
    endtask

    task automatic bit_cycle(input bit [2:0] acc, input int cyc, input int sw_tick);
        for (int t = 0; t < 4; t++) step(1'b0, acc, cyc, t, 1'b0, 0, 0, 1'b0, t == sw_tick);
    endtask

    task automatic wr(input int ch, input int cyc, input bit d, input bit sw);
        step(1'b0, 3'd0, 0, 3, 1'b1, ch, cyc, d, sw);
    endtask

    task automatic idle_swap();
        step(1'b0, 3'd0, 0, 3, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    // Monitor: compares every scoreboard entry in the cycle it was issued for
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (DOUT !== e.dout) begin
                    errors++;
                    $display("FAIL dout step %0d: got %b expected %b", e.id, DOUT, e.dout);
                end
                checks++;
                if (BANKRDY !== e.bankrdy) begin
                    errors++;
                    $display("FAIL bankrdy step %0d: got %b expected %b", e.id, BANKRDY, e.bankrdy);
                end
                checks++;
                if (OVERRUN !== e.overrun) begin
                    errors++;
                    $display("FAIL overrun step %0d: got %b expected %b", e.id, OVERRUN, e.overrun);
                end
            end
        end
    end

    initial begin
        bit d;
        int cyc;
        int wait_cnt;

        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Fill both banks at every address the bench reads
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NADDR; i++)
                for (int c = 0; c < CH; c++) wr(c, addr_of(i), 1'($urandom_range(0, 1)), 1'b0);
            idle_swap();
        end

        // Single bit on ch0 at cycle 5, streamed after an idle swap
        wr(0, 5, 1'b1, 1'b0);
        for (int c = 1; c < CH; c++) wr(c, 5, 1'b0, 1'b0);
        idle_swap();
        bit_cycle(3'd1, 5, -1);
        bit_cycle(3'd0, 5, -1);

        // Swap requested while active is deferred to the first idle cycle
        bit_cycle(3'd1, 6, 1);
        bit_cycle(3'd1, 7, -1);
        bit_cycle(3'd0, 0, -1);
        bit_cycle(3'd1, 5, -1);

        // Second swap in one active window is dropped and flags overrun
        bit_cycle(3'd2, 8, 1);
        bit_cycle(3'd2, 9, 2);
        bit_cycle(3'd0, 0, -1);
        bit_cycle(3'd2, 8, -1);

        // Write coinciding with the swap edge lands in the pre-swap write bank
        d = ~mdl[m_rdbank ^ 1'b1][0][3];
        wr(0, 3, d, 1'b1);
        bit_cycle(3'd1, 3, -1);

        // Channel 3 across the cycle-number wrap
        wr(3, 4094, 1'b0, 1'b0);
        wr(3, 4095, 1'b1, 1'b0);
        wr(3, 0, 1'b0, 1'b0);
        idle_swap();
        bit_cycle(3'd1, 4094, -1);
        bit_cycle(3'd1, 4095, -1);
        bit_cycle(3'd1, 0, -1);

        // Reset while a swap is pending, then read bank A
        bit_cycle(3'd1, 5, 0);
        step(1'b0, 3'd1, 6, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 6, 1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 6, 2, 1'b0, 0, 0, 1'b0, 1'b0);
        bit_cycle(3'd1, 5, -1);
        bit_cycle(3'd1, 4095, -1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit [2:0] acc;
            int       swt;
            acc = ($urandom_range(0, 99) < 70) ? 3'($urandom_range(1, 7)) : 3'd0;
            cyc = addr_of($urandom_range(0, NADDR - 1));
            swt = ($urandom_range(0, 99) < 20) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 99) < 2) begin
                step(1'b1, 3'd0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
            end
            for (int t = 0; t < 4; t++) begin
                bit we;
                we = ($urandom_range(0, 99) < 30);
                step(1'b0, acc, cyc, t, we, $urandom_range(0, CH - 1),
                     addr_of($urandom_range(0, NADDR - 1)), 1'($urandom_range(0, 1)), t == swt);
            end
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
